// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC gain-compensation stage: default lane
// geometry, the packed {x, y} lane layout and the controller state encoding.
package cordic_pkg;

  localparam int LANE_W     = 16;
  localparam int K_COEF_DEF = 19898;
  localparam int FRAC_DEF   = 15;

  // Lane slot inside the packed word: x occupies the upper half.
  localparam int X_LANE = 1;
  localparam int Y_LANE = 0;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  function automatic logic [2*LANE_W-1:0] pack_xy(input logic [LANE_W-1:0] x,
                                                  input logic [LANE_W-1:0] y);
    return {x, y};
  endfunction

endpackage

// File: rtl/cordic_gain_lane.sv
// One lane of the gain compensator: bit-serial shift-add multiply by K_COEF,
// then round half toward +inf and saturate back to WIDTH bits.
import cordic_pkg::*;

module cordic_gain_lane #(
  parameter int          WIDTH  = LANE_W,
  parameter int unsigned K_COEF = K_COEF_DEF,
  parameter int          FRAC   = FRAC_DEF,
  parameter int          CW     = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             step,
  input  logic             last,
  input  logic [CW-1:0]    bit_idx,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = WIDTH + FRAC + 2;
  localparam logic [WIDTH-1:0]     K_BITS = WIDTH'(K_COEF);
  localparam logic signed [AW-1:0] HALF   = AW'(2 ** (FRAC - 1));
  localparam logic signed [AW-1:0] MAX_V  = AW'(2 ** (WIDTH - 1) - 1);
  localparam logic signed [AW-1:0] MIN_V  = ~MAX_V;

  logic signed [AW-1:0] op_p0;
  logic signed [AW-1:0] acc_p1;
  logic signed [AW-1:0] term;
  logic signed [AW-1:0] acc_next;
  logic [WIDTH-1:0]     res_p2;

  function automatic logic signed [AW-1:0] round_half_up(input logic signed [AW-1:0] p);
    return (p + HALF) >>> FRAC;
  endfunction

  function automatic logic [WIDTH-1:0] saturate(input logic signed [AW-1:0] r);
    logic signed [AW-1:0] c;
    if (r > MAX_V)      c = MAX_V;
    else if (r < MIN_V) c = MIN_V;
    else                c = r;
    return c[WIDTH-1:0];
  endfunction

  always_comb begin
    term = '0;
    if (K_BITS[bit_idx]) term = op_p0 <<< bit_idx;
    acc_next = acc_p1 + term;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_p0  <= '0;
      acc_p1 <= '0;
      res_p2 <= '0;
    end else begin
      // p0: operand capture / p1: partial-product accumulation
      if (load) begin
        op_p0  <= {{(AW-WIDTH){din[WIDTH-1]}}, din};
        acc_p1 <= '0;
      end else if (step) begin
        acc_p1 <= acc_next;
      end
      // p2: the final partial product is folded in before rounding
      if (step && last) res_p2 <= saturate(round_half_up(acc_next));
    end
  end

  assign dout = res_p2;

endmodule

// File: rtl/cordic_gain_comp.sv
// CORDIC gain compensation: scales both packed lanes by K with a shared
// WIDTH-cycle bit-serial controller and a valid/ready handshake on each side.
import cordic_pkg::*;

module cordic_gain_comp #(
  parameter int          WIDTH  = LANE_W,
  parameter int unsigned K_COEF = K_COEF_DEF,
  parameter int          FRAC   = FRAC_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [2*WIDTH-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int CW = $clog2(WIDTH);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          step;
  logic          last;

  assign accept = in_valid && in_ready;
  assign step   = (state == MUL);
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = MUL;
      end
      MUL: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    cnt <= '0;
    else if (accept) cnt <= '0;
    else if (step)   cnt <= cnt + CW'(1);
  end

  cordic_gain_lane #(
    .WIDTH(WIDTH), .K_COEF(K_COEF), .FRAC(FRAC), .CW(CW)
  ) u_lane_x (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (accept),
    .step    (step),
    .last    (last),
    .bit_idx (cnt),
    .din     (in_data[X_LANE*WIDTH +: WIDTH]),
    .dout    (out_data[X_LANE*WIDTH +: WIDTH])
  );

  cordic_gain_lane #(
    .WIDTH(WIDTH), .K_COEF(K_COEF), .FRAC(FRAC), .CW(CW)
  ) u_lane_y (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (accept),
    .step    (step),
    .last    (last),
    .bit_idx (cnt),
    .din     (in_data[Y_LANE*WIDTH +: WIDTH]),
    .dout    (out_data[Y_LANE*WIDTH +: WIDTH])
  );

endmodule

// File: tb/tb_cordic_gain_comp.sv
// Bench for cordic_gain_comp: three instances (default K, K=65535, K=0) share
// one stimulus stream; expected words are queued on accept and popped on output.
import cordic_pkg::*;

module tb_cordic_gain_comp;

  typedef struct {
    logic [31:0] d;
    logic [31:0] s;
    logic [31:0] z;
  } exp_t;

  typedef struct {
    int x, y, dx, dy, sx, sy;
  } vec_t;

  logic        clock;
  logic        reset_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        out_ready;
  logic        in_ready, in_ready_s, in_ready_z;
  logic        out_valid, out_valid_s, out_valid_z;
  logic [31:0] out_data, out_data_s, out_data_z;

  int   tests  = 0;
  int   failed = 0;
  exp_t sb[$];
  vec_t tbl[6];

  cordic_gain_comp dut (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  cordic_gain_comp #(.K_COEF(65535)) dut_sat (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_s), .out_data(out_data_s), .out_valid(out_valid_s), .out_ready(out_ready)
  );

  cordic_gain_comp #(.K_COEF(0)) dut_zero (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_z), .out_data(out_data_z), .out_valid(out_valid_z), .out_ready(out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input int x, input longint k);
    longint p, r;
    p = longint'(x) * k;
    r = (p + 64'sd16384) >>> 15;
    if (r > 32767)       r = 32767;
    else if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  function automatic exp_t model_exp(input int x, input int y);
    exp_t e;
    e.d = pack_xy(model(x, 19898), model(y, 19898));
    e.s = pack_xy(model(x, 65535), model(y, 65535));
    e.z = pack_xy(model(x, 0), model(y, 0));
    return e;
  endfunction

  task automatic accept(input int x, input int y, input exp_t e);
    int w = 0;
    in_data  = pack_xy(16'(x), 16'(y));
    in_valid = 1'b1;
    while (!in_ready && w < 50) begin
      @(posedge clock); #1;
      w++;
    end
    check("accept_ready", {in_ready, in_ready_s, in_ready_z}, 3'b111);
    sb.push_back(e);
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic collect(input string name);
    int   lat = 0;
    exp_t e;
    while (!out_valid && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    check({name, "_latency"}, lat, 16);
    check({name, "_valid"}, {out_valid, out_valid_s, out_valid_z}, 3'b111);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({name, "_data"}, {out_data, out_data_s, out_data_z}, {e.d, e.s, e.z});
    end else begin
      check({name, "_scoreboard"}, 0, 1);
    end
    if (out_ready) begin
      @(posedge clock); #1;
      check({name, "_release"},
            {out_valid, out_valid_s, out_valid_z, in_ready, in_ready_s, in_ready_z}, 6'b000111);
    end
  endtask

  initial begin
    exp_t e;
    logic signed [15:0] rx, ry;
    logic seen;

    tbl[0] = '{16384, -16384, 9949, -9949, 32767, -32767};
    tbl[1] = '{32767, -32768, 19897, -19898, 32767, -32768};
    tbl[2] = '{1, -1, 1, -1, 2, -2};
    tbl[3] = '{0, 0, 0, 0, 0, 0};
    tbl[4] = '{100, -100, 61, -61, 200, -200};
    tbl[5] = '{-32768, 32767, -19898, 19897, -32768, 32767};

    reset_n   = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    #2 reset_n = 1'b0;
    #1;
    check("rst_out_valid", {out_valid, out_valid_s, out_valid_z}, 3'b000);
    check("rst_out_data", {out_data, out_data_s, out_data_z}, 96'd0);
    check("rst_in_ready", {in_ready, in_ready_s, in_ready_z}, 3'b111);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
    check("post_rst_idle", {out_valid, in_ready}, 2'b01);

    for (int i = 0; i < 6; i++) begin
      e.d = pack_xy(16'(tbl[i].dx), 16'(tbl[i].dy));
      e.s = pack_xy(16'(tbl[i].sx), 16'(tbl[i].sy));
      e.z = '0;
      accept(tbl[i].x, tbl[i].y, e);
      collect($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      accept(int'(rx), int'(ry), model_exp(int'(rx), int'(ry)));
      collect($sformatf("rnd%0d", i));
    end

    // Backpressure: hold DONE, present a second operand that must wait.
    out_ready = 1'b0;
    e.d = pack_xy(16'd9949, -16'sd9949);
    e.s = pack_xy(16'd32767, -16'sd32767);
    e.z = '0;
    accept(16384, -16384, e);
    collect("bp_first");
    in_data  = pack_xy(16'd100, -16'sd100);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      check($sformatf("bp_hold%0d", i), {out_valid, in_ready, out_data}, {1'b1, 1'b0, e.d});
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    check("bp_release", {out_valid, in_ready}, 2'b01);
    e.d = pack_xy(16'd61, -16'sd61);
    e.s = pack_xy(16'd200, -16'sd200);
    e.z = '0;
    accept(100, -100, e);
    collect("bp_second");

    // Reset in the middle of a multiply: nothing may come out.
    accept(500, -500, model_exp(500, -500));
    repeat (7) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_state", {out_valid, out_valid_s, out_valid_z, in_ready, in_ready_s, in_ready_z},
          6'b000111);
    check("midrst_data", {out_data, out_data_s, out_data_z}, 96'd0);
    void'(sb.pop_back());
    @(negedge clock) reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clock); #1;
      seen |= out_valid | out_valid_s | out_valid_z;
    end
    check("midrst_no_valid", seen, 1'b0);
    accept(-12345, 23456, model_exp(-12345, 23456));
    collect("after_rst");

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
